pong_draw_controller: RTL

Sequences rectangle draws onto the shared VGA adapter pixel port for the Pong game. Up to `NUM_REQ` game objects (left paddle, right paddle, ball, erase/score) request a filled rectangle. The block picks one by round-robin arbitration and walks its pixels in raster order, driving `x`, `y`, `colour` and `plot` one pixel per cycle. It sits between the game-logic FSMs and the `vga_adapter` instance in `pong`.

---
 rtl/pong_defs.sv | 25 ++
 rtl/pong_draw_controller_rr_arbiter.sv | 43 ++++
 rtl/pong_draw_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pong_defs.sv
// Shared Pong screen geometry and draw-state encodings, reused by the game-logic FSMs
// and the rectangle draw controller.
package pong_defs;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    // Pixel sums carry one extra bit so that off-screen coordinates are detected.
    localparam logic [X_W:0] X_LIMIT = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIMIT = (Y_W + 1)'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

    function automatic logic on_screen(input logic [X_W:0] xs, input logic [Y_W:0] ys);
        return (xs < X_LIMIT) && (ys < Y_LIMIT);
    endfunction

endpackage

// File: rtl/pong_draw_controller_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner, and the pointer
// advances only when a grant is taken while enabled.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] last
);

    logic             found;
    logic [IDX_W-1:0] win;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        grant = '0;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win        = IDX_W'(idx);
                found      = 1'b1;
            end
        end
    end

    // Resetting to N-1 makes requester 0 the first one searched.
    always_ff @(posedge clock) begin
        if (reset) begin
            last <= IDX_W'(N - 1);
        end else if (enable && found) begin
            last <= win;
        end
    end

endmodule

// File: rtl/pong_draw_controller.sv
// Arbitrates rectangle draw requests and walks the winner's pixels in raster order,
// one registered pixel per cycle, onto the VGA adapter pixel port.
module pong_draw_controller
    import pong_defs::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIM_W   = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*X_W-1:0]        req_x,
    input  logic [NUM_REQ*Y_W-1:0]        req_y,
    input  logic [NUM_REQ*DIM_W-1:0]      req_w,
    input  logic [NUM_REQ*DIM_W-1:0]      req_h,
    input  logic [NUM_REQ*COLOUR_W-1:0]   req_colour,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic [X_W-1:0]                x,
    output logic [Y_W-1:0]                y,
    output logic [COLOUR_W-1:0]           colour,
    output logic                          plot
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_XW = X_W + 1;
    localparam int SUM_YW = Y_W + 1;

    localparam logic [DIM_W-1:0]   DIM_ONE = DIM_W'(1);
    localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

    draw_state_t state;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    arb_last;

    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [DIM_W-1:0]    sel_w;
    logic [DIM_W-1:0]    sel_h;
    logic [COLOUR_W-1:0] sel_colour;

    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [DIM_W-1:0]    w;
    logic [DIM_W-1:0]    h;
    logic [COLOUR_W-1:0] fill;
    logic [DIM_W-1:0]    cx;
    logic [DIM_W-1:0]    cy;

    logic                last_px;
    logic [DIM_W-1:0]    nx_cx;
    logic [DIM_W-1:0]    nx_cy;
    logic [X_W-1:0]      base_x;
    logic [Y_W-1:0]      base_y;
    logic [DIM_W-1:0]    off_x;
    logic [DIM_W-1:0]    off_y;
    logic [SUM_XW-1:0]   sum_x;
    logic [SUM_YW-1:0]   sum_y;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (state == IDLE),
        .req    (req),
        .grant  (grant),
        .last   (arb_last)
    );

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_w      = '0;
        sel_h      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_w      = req_w[i*DIM_W +: DIM_W];
                sel_h      = req_h[i*DIM_W +: DIM_W];
                sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    // In IDLE the adders produce the first pixel straight from the winner's fields,
    // so plot can rise in the cycle right after the grant.
    always_comb begin
        last_px = (cx == w - DIM_ONE) && (cy == h - DIM_ONE);
        if (cx == w - DIM_ONE) begin
            nx_cx = '0;
            nx_cy = cy + DIM_ONE;
        end else begin
            nx_cx = cx + DIM_ONE;
            nx_cy = cy;
        end
        if (state == IDLE) begin
            base_x = sel_x;
            base_y = sel_y;
            off_x  = '0;
            off_y  = '0;
        end else begin
            base_x = x0;
            base_y = y0;
            off_x  = nx_cx;
            off_y  = nx_cy;
        end
        sum_x = {1'b0, base_x} + SUM_XW'(off_x);
        sum_y = {1'b0, base_y} + SUM_YW'(off_y);
    end

    // NOTE: sequential state uses non-blocking assignments only; the datapath registers
    // are reset as well so an aborted draw leaves nothing stale on the pixel port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ack    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            x0     <= '0;
            y0     <= '0;
            w      <= '0;
            h      <= '0;
            fill   <= '0;
            cx     <= '0;
            cy     <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        x0   <= sel_x;
                        y0   <= sel_y;
                        w    <= sel_w;
                        h    <= sel_h;
                        fill <= sel_colour;
                        cx   <= '0;
                        cy   <= '0;
                        ack  <= grant;
                        busy <= 1'b1;
                        if (sel_w == '0 || sel_h == '0) begin
                            state <= DONE;
                            done  <= grant;
                            plot  <= 1'b0;
                        end else begin
                            state  <= DRAW;
                            x      <= sum_x[X_W-1:0];
                            y      <= sum_y[Y_W-1:0];
                            colour <= sel_colour;
                            plot   <= on_screen(sum_x, sum_y);
                        end
                    end
                end
                DRAW: begin
                    if (last_px) begin
                        state <= DONE;
                        plot  <= 1'b0;
                        done  <= REQ_ONE << arb_last;
                    end else begin
                        cx     <= nx_cx;
                        cy     <= nx_cy;
                        x      <= sum_x[X_W-1:0];
                        y      <= sum_y[Y_W-1:0];
                        colour <= fill;
                        plot   <= on_screen(sum_x, sum_y);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule
